// File: rtl/ref_home_pkg.sv
// Shared constants for the reference-homing sequencer: widths and FSM encoding.
package ref_home_pkg;

  localparam int POS_W  = 20;  // pulse position count width
  localparam int TMO_W  = 20;  // timeout step counter width
  localparam int FCNT_W = 4;   // debounce filter counter width

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  // Saturating increment: the timeout count sticks at all-ones instead of wrapping.
  function automatic logic [TMO_W-1:0] sat_inc(input logic [TMO_W-1:0] v);
    return (v == {TMO_W{1'b1}}) ? v : v + TMO_W'(1);
  endfunction

endpackage

// File: rtl/ref_debounce.sv
// Two-flop synchronizer and consecutive-sample debounce filter for the raw
// reference switch. RefFall is a one-cycle strobe on a filtered 1->0 change.
module ref_debounce
  import ref_home_pkg::*;
#(
  parameter int DEB_LEN = 4
) (
  input  logic Clk,
  input  logic RefDoneClr,
  input  logic Ref,
  output logic RefF,
  output logic RefFall
);

  // The filter flips on the cycle the mismatch count would reach DEB_LEN.
  localparam logic [FCNT_W-1:0] CNT_LAST = FCNT_W'(DEB_LEN - 1);

  logic              s0_q, s1_q;
  logic              ref_f_q, ref_f_d;
  logic              ref_prev_q;
  logic [FCNT_W-1:0] cnt_q, cnt_d;

  // Synchronize the asynchronous switch input; idle level is high.
  always_ff @(posedge Clk or posedge RefDoneClr) begin
    if (RefDoneClr) begin
      s0_q <= 1'b1;
      s1_q <= 1'b1;
    end else begin
      s0_q <= Ref;
      s1_q <= s0_q;
    end
  end

  // Count consecutive samples disagreeing with the filtered level.
  always_comb begin
    ref_f_d = ref_f_q;
    cnt_d   = '0;
    if (s1_q != ref_f_q) begin
      if (cnt_q == CNT_LAST) begin
        ref_f_d = s1_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + FCNT_W'(1);
      end
    end
  end

  // Filtered level, its previous value for edge detection, and the counter.
  always_ff @(posedge Clk or posedge RefDoneClr) begin
    if (RefDoneClr) begin
      ref_f_q    <= 1'b1;
      ref_prev_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      ref_f_q    <= ref_f_d;
      ref_prev_q <= ref_f_q;
      cnt_q      <= cnt_d;
    end
  end

  assign RefF    = ref_f_q;
  assign RefFall = ref_prev_q & ~ref_f_q;

endmodule

// File: rtl/ref_home_seq.sv
// Reference homing sequencer: seeks the reference switch while enabled,
// clears the downstream position counter on the filtered switch edge and
// captures the position at that moment; faults if the seek runs too long.
//
// Handshake: none; StepStb is a single-cycle qualifier, Refpls a single-cycle
// strobe emitted only on the ARMED->DONE transition.
module ref_home_seq
  import ref_home_pkg::*;
#(
  parameter int               DEB_LEN       = 4,
  parameter logic [TMO_W-1:0] TIMEOUT_STEPS = 20'd100000
) (
  input  logic             Clk,
  input  logic             RefDoneClr,
  input  logic             RefEn,
  input  logic             Ref,
  input  logic             StepStb,
  input  logic [POS_W-1:0] PlsCntIn,
  output logic             RunReq,
  output logic             Refpls,
  output logic             RefDone,
  output logic [POS_W-1:0] RefPosLatch,
  output logic             TimeoutErr,
  output logic             Busy
);

  logic             ref_f, ref_fall;
  logic [1:0]       state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [TMO_W-1:0] tmo_inc;
  logic             refpls_q, refpls_d;
  logic             done_q, done_d;
  logic             terr_q, terr_d;
  logic [POS_W-1:0] latch_q, latch_d;

  ref_debounce #(.DEB_LEN(DEB_LEN)) u_deb (
    .Clk        (Clk),
    .RefDoneClr (RefDoneClr),
    .Ref        (Ref),
    .RefF       (ref_f),
    .RefFall    (ref_fall)
  );

  assign tmo_inc = sat_inc(tmo_q);

  // Next-state logic; abort beats the switch edge, the edge beats timeout.
  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    refpls_d = 1'b0;
    done_d   = done_q;
    terr_d   = terr_q;
    latch_d  = latch_q;
    case (state_q)
      ST_IDLE: begin
        // With the switch already engaged there is no edge to find: wait.
        if (RefEn && ref_f) begin
          state_d = ST_ARMED;
          tmo_d   = '0;
        end
      end
      ST_ARMED: begin
        if (!RefEn) begin
          state_d = ST_IDLE;
          tmo_d   = '0;
        end else if (ref_fall) begin
          state_d  = ST_DONE;
          refpls_d = 1'b1;
          done_d   = 1'b1;
          latch_d  = PlsCntIn;
        end else if (StepStb) begin
          tmo_d = tmo_inc;
          if ((TIMEOUT_STEPS != '0) && (tmo_inc == TIMEOUT_STEPS)) begin
            state_d = ST_FAULT;
            terr_d  = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      ST_FAULT: begin
        if (!RefEn) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, timeout counter, sticky flags and capture register.
  always_ff @(posedge Clk or posedge RefDoneClr) begin
    if (RefDoneClr) begin
      state_q  <= ST_IDLE;
      tmo_q    <= '0;
      refpls_q <= 1'b0;
      done_q   <= 1'b0;
      terr_q   <= 1'b0;
      latch_q  <= '0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      refpls_q <= refpls_d;
      done_q   <= done_d;
      terr_q   <= terr_d;
      latch_q  <= latch_d;
    end
  end

  assign RunReq      = (state_q == ST_ARMED);
  assign Busy        = (state_q == ST_ARMED);
  assign Refpls      = refpls_q;
  assign RefDone     = done_q;
  assign TimeoutErr  = terr_q;
  assign RefPosLatch = latch_q;

endmodule

// File: tb/tb_ref_home_seq.sv
// Bench for ref_home_seq: scenario tasks with inline checks, plus a Refpls
// monitor that pops expected capture values from a scoreboard queue.
module tb_ref_home_seq;

  localparam int          DEB = 4;
  localparam logic [19:0] TMO = 20'd5;

  logic        Clk = 1'b0;
  logic        RefDoneClr;
  logic        RefEn;
  logic        Ref;
  logic        StepStb;
  logic [19:0] PlsCntIn;
  logic        RunReq;
  logic        Refpls;
  logic        RefDone;
  logic [19:0] RefPosLatch;
  logic        TimeoutErr;
  logic        Busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pulse_cnt = 0;
  int pulse_cyc = -1;
  int p0;
  int k;
  logic [19:0] exp_q[$];
  logic [19:0] exp_v;

  ref_home_seq #(.DEB_LEN(DEB), .TIMEOUT_STEPS(TMO)) dut (
    .Clk         (Clk),
    .RefDoneClr  (RefDoneClr),
    .RefEn       (RefEn),
    .Ref         (Ref),
    .StepStb     (StepStb),
    .PlsCntIn    (PlsCntIn),
    .RunReq      (RunReq),
    .Refpls      (Refpls),
    .RefDone     (RefDone),
    .RefPosLatch (RefPosLatch),
    .TimeoutErr  (TimeoutErr),
    .Busy        (Busy)
  );

  // ---------------- clock / reset block ----------------
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge Clk) begin
    if (Refpls === 1'b1) begin
      pulse_cnt = pulse_cnt + 1;
      pulse_cyc = cyc;
      total = total + 1;
      if (exp_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL refpls_unexpected cyc=%0d latch=%h", cyc, RefPosLatch);
      end else begin
        exp_v = exp_q.pop_front();
        if (RefPosLatch !== exp_v) begin
          bad = bad + 1;
          $display("FAIL refpos_latch got=%h want=%h", RefPosLatch, exp_v);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clk1(input logic stb);
    @(posedge Clk);
    #1;
    StepStb = stb;
  endtask

  task automatic do_reset();
    @(posedge Clk);
    #1;
    RefDoneClr = 1'b1;
    RefEn      = 1'b0;
    Ref        = 1'b1;
    StepStb    = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    RefDoneClr = 1'b0;
  endtask

  task automatic arm();
    RefEn = 1'b1;
    clk1(1'b0);
    clk1(1'b0);
  endtask

  // Drop Ref right after a posedge; the next posedge is edge k.
  task automatic drop_ref();
    clk1(1'b0);
    Ref = 1'b0;
    k = cyc + 1;
    exp_q.push_back(PlsCntIn);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RefDoneClr = 1'b1;
    RefEn      = 1'b1;
    Ref        = 1'b0;
    StepStb    = 1'b1;
    PlsCntIn   = 20'hFFFFF;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    total++; if (RunReq !== 1'b0) begin bad++; $display("FAIL reset_runreq got=%b want=0", RunReq); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", Busy); end
    total++; if (RefDone !== 1'b0) begin bad++; $display("FAIL reset_refdone got=%b want=0", RefDone); end
    total++; if (Refpls !== 1'b0) begin bad++; $display("FAIL reset_refpls got=%b want=0", Refpls); end
    total++; if (TimeoutErr !== 1'b0) begin bad++; $display("FAIL reset_terr got=%b want=0", TimeoutErr); end
    total++; if (RefPosLatch !== 20'h0) begin bad++; $display("FAIL reset_latch got=%h want=00000", RefPosLatch); end
    RefEn   = 1'b0;
    Ref     = 1'b1;
    StepStb = 1'b0;
    RefDoneClr = 1'b0;
  endtask

  task automatic test_seek();
    do_reset();
    PlsCntIn = 20'h01234;
    arm();
    @(negedge Clk);
    total++; if (Busy !== 1'b1) begin bad++; $display("FAIL seek_busy got=%b want=1", Busy); end
    total++; if (RunReq !== 1'b1) begin bad++; $display("FAIL seek_runreq got=%b want=1", RunReq); end
    repeat (3) begin
      clk1(1'b1);
      repeat (9) clk1(1'b0);
    end
    p0 = pulse_cnt;
    drop_ref();
    repeat (12) clk1(1'b0);
    @(negedge Clk);
    total++; if (pulse_cnt - p0 != 1) begin bad++; $display("FAIL seek_pulse_count got=%0d want=1", pulse_cnt - p0); end
    total++; if (pulse_cyc != k + 6) begin bad++; $display("FAIL seek_latency got=%0d want=%0d", pulse_cyc, k + 6); end
    total++; if (RefDone !== 1'b1) begin bad++; $display("FAIL seek_refdone got=%b want=1", RefDone); end
    total++; if (RunReq !== 1'b0) begin bad++; $display("FAIL seek_runreq_off got=%b want=0", RunReq); end
    total++; if (RefPosLatch !== 20'h01234) begin bad++; $display("FAIL seek_latch got=%h want=01234", RefPosLatch); end
    // DONE holds through enable and switch changes
    RefEn = 1'b0;
    Ref = 1'b1;
    PlsCntIn = 20'h0BEEF;
    repeat (10) clk1(1'b0);
    RefEn = 1'b1;
    repeat (10) clk1(1'b0);
    @(negedge Clk);
    total++; if (RefDone !== 1'b1) begin bad++; $display("FAIL done_hold_refdone got=%b want=1", RefDone); end
    total++; if (RunReq !== 1'b0) begin bad++; $display("FAIL done_hold_runreq got=%b want=0", RunReq); end
    total++; if (RefPosLatch !== 20'h01234) begin bad++; $display("FAIL done_hold_latch got=%h want=01234", RefPosLatch); end
    total++; if (pulse_cnt - p0 != 1) begin bad++; $display("FAIL done_hold_pulses got=%0d want=1", pulse_cnt - p0); end
  endtask

  task automatic test_reset_rehome();
    // currently DONE with RefEn=1, Ref=1
    @(posedge Clk);
    #1;
    RefDoneClr = 1'b1;
    #2;
    total++; if (RefDone !== 1'b0) begin bad++; $display("FAIL clr_refdone got=%b want=0", RefDone); end
    total++; if (RefPosLatch !== 20'h0) begin bad++; $display("FAIL clr_latch got=%h want=00000", RefPosLatch); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL clr_busy got=%b want=0", Busy); end
    @(negedge Clk);
    RefDoneClr = 1'b0;
    PlsCntIn = 20'h00ABC;
    repeat (5) clk1(1'b0);
    @(negedge Clk);
    total++; if (Busy !== 1'b1) begin bad++; $display("FAIL rehome_busy got=%b want=1", Busy); end
    p0 = pulse_cnt;
    drop_ref();
    repeat (12) clk1(1'b0);
    @(negedge Clk);
    total++; if (pulse_cnt - p0 != 1) begin bad++; $display("FAIL rehome_pulses got=%0d want=1", pulse_cnt - p0); end
    total++; if (pulse_cyc != k + 6) begin bad++; $display("FAIL rehome_latency got=%0d want=%0d", pulse_cyc, k + 6); end
    total++; if (RefPosLatch !== 20'h00ABC) begin bad++; $display("FAIL rehome_latch got=%h want=00ABC", RefPosLatch); end
  endtask

  task automatic test_glitch();
    do_reset();
    PlsCntIn = 20'h55AA5;
    arm();
    p0 = pulse_cnt;
    clk1(1'b0);
    Ref = 1'b0;
    repeat (3) clk1(1'b0);
    Ref = 1'b1;
    repeat (12) clk1(1'b0);
    @(negedge Clk);
    total++; if (pulse_cnt - p0 != 0) begin bad++; $display("FAIL glitch_pulses got=%0d want=0", pulse_cnt - p0); end
    total++; if (Busy !== 1'b1) begin bad++; $display("FAIL glitch_busy got=%b want=1", Busy); end
    total++; if (RefDone !== 1'b0) begin bad++; $display("FAIL glitch_refdone got=%b want=0", RefDone); end
    drop_ref();
    repeat (4) clk1(1'b0);
    Ref = 1'b1;
    repeat (10) clk1(1'b0);
    @(negedge Clk);
    total++; if (pulse_cnt - p0 != 1) begin bad++; $display("FAIL deb4_pulses got=%0d want=1", pulse_cnt - p0); end
    total++; if (pulse_cyc != k + 6) begin bad++; $display("FAIL deb4_latency got=%0d want=%0d", pulse_cyc, k + 6); end
    total++; if (RefDone !== 1'b1) begin bad++; $display("FAIL deb4_refdone got=%b want=1", RefDone); end
  endtask

  task automatic test_abort();
    do_reset();
    PlsCntIn = 20'h00777;
    arm();
    repeat (4) begin clk1(1'b1); clk1(1'b0); end
    p0 = pulse_cnt;
    RefEn = 1'b0;
    clk1(1'b0);
    clk1(1'b0);
    @(negedge Clk);
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", Busy); end
    total++; if (RunReq !== 1'b0) begin bad++; $display("FAIL abort_runreq got=%b want=0", RunReq); end
    total++; if (RefPosLatch !== 20'h0) begin bad++; $display("FAIL abort_latch got=%h want=00000", RefPosLatch); end
    // Re-entry restarts the timeout count: four more strobes must not fault.
    arm();
    repeat (4) begin clk1(1'b1); clk1(1'b0); end
    @(negedge Clk);
    total++; if (Busy !== 1'b1) begin bad++; $display("FAIL rearm_busy got=%b want=1", Busy); end
    total++; if (TimeoutErr !== 1'b0) begin bad++; $display("FAIL rearm_terr got=%b want=0", TimeoutErr); end
    total++; if (pulse_cnt - p0 != 0) begin bad++; $display("FAIL abort_pulses got=%0d want=0", pulse_cnt - p0); end
  endtask

  task automatic test_timeout();
    do_reset();
    arm();
    repeat (4) begin clk1(1'b1); clk1(1'b0); end
    @(negedge Clk);
    total++; if (TimeoutErr !== 1'b0) begin bad++; $display("FAIL tmo_early_terr got=%b want=0", TimeoutErr); end
    total++; if (Busy !== 1'b1) begin bad++; $display("FAIL tmo_early_busy got=%b want=1", Busy); end
    clk1(1'b1);
    clk1(1'b0);
    @(negedge Clk);
    total++; if (TimeoutErr !== 1'b1) begin bad++; $display("FAIL tmo_terr got=%b want=1", TimeoutErr); end
    total++; if (RunReq !== 1'b0) begin bad++; $display("FAIL tmo_runreq got=%b want=0", RunReq); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL tmo_busy got=%b want=0", Busy); end
    RefEn = 1'b0;
    clk1(1'b0);
    clk1(1'b0);
    arm();
    @(negedge Clk);
    total++; if (Busy !== 1'b1) begin bad++; $display("FAIL fault_idle_rearm got=%b want=1", Busy); end
    total++; if (TimeoutErr !== 1'b1) begin bad++; $display("FAIL fault_sticky got=%b want=1", TimeoutErr); end
    RefEn = 1'b0;
    clk1(1'b0);
  endtask

  task automatic test_simul();
    do_reset();
    PlsCntIn = 20'h0C0DE;
    arm();
    repeat (4) begin clk1(1'b1); clk1(1'b0); end
    p0 = pulse_cnt;
    drop_ref();
    repeat (5) clk1(1'b0);
    clk1(1'b1);
    clk1(1'b0);
    repeat (5) clk1(1'b0);
    @(negedge Clk);
    total++; if (pulse_cnt - p0 != 1) begin bad++; $display("FAIL simul_pulses got=%0d want=1", pulse_cnt - p0); end
    total++; if (pulse_cyc != k + 6) begin bad++; $display("FAIL simul_latency got=%0d want=%0d", pulse_cyc, k + 6); end
    total++; if (RefDone !== 1'b1) begin bad++; $display("FAIL simul_refdone got=%b want=1", RefDone); end
    total++; if (TimeoutErr !== 1'b0) begin bad++; $display("FAIL simul_terr got=%b want=0", TimeoutErr); end
  endtask

  task automatic test_engaged();
    do_reset();
    p0 = pulse_cnt;
    Ref = 1'b0;
    repeat (10) clk1(1'b0);
    RefEn = 1'b1;
    repeat (10) clk1(1'b0);
    @(negedge Clk);
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL engaged_busy got=%b want=0", Busy); end
    total++; if (RunReq !== 1'b0) begin bad++; $display("FAIL engaged_runreq got=%b want=0", RunReq); end
    total++; if (pulse_cnt - p0 != 0) begin bad++; $display("FAIL engaged_pulses got=%0d want=0", pulse_cnt - p0); end
    clk1(1'b0);
    Ref = 1'b1;
    k = cyc + 1;
    repeat (6) clk1(1'b0);
    @(negedge Clk);
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL engaged_release_early got=%b want=0 cyc=%0d", Busy, cyc); end
    clk1(1'b0);
    @(negedge Clk);
    total++; if (Busy !== 1'b1) begin bad++; $display("FAIL engaged_release_arm got=%b want=1 cyc=%0d", Busy, cyc); end
    RefEn = 1'b0;
    clk1(1'b0);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    RefDoneClr = 1'b1;
    RefEn      = 1'b0;
    Ref        = 1'b1;
    StepStb    = 1'b0;
    PlsCntIn   = 20'h0;
    test_reset();
    test_seek();
    test_reset_rehome();
    test_glitch();
    test_abort();
    test_timeout();
    test_simul();
    test_engaged();
    repeat (3) clk1(1'b0);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
